// File: rtl/pu_riscv_ahb3_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pu_riscv_ahb3_pkg
// Brief    : AHB3-Lite encodings and slave-memory state type
// Revision : 1.0 - initial release
// ============================================================================
package pu_riscv_ahb3_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HWORD = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } ahb3_state_t;

endpackage
`default_nettype wire

// File: rtl/pu_riscv_ahb3_lanes.sv
`default_nettype none
// ============================================================================
// Module   : pu_riscv_ahb3_lanes
// Brief    : Byte-strobe decoder from lane offset and HSIZE, flags bad size/alignment
// Revision : 1.0 - initial release
// ============================================================================
module pu_riscv_ahb3_lanes #(
  parameter int XLEN = 32
) (
  input  logic [$clog2(XLEN/8)-1:0] i_offset,
  input  logic [2:0]                i_size,
  output logic [XLEN/8-1:0]         o_strb,
  output logic                      o_err
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  always_comb begin
    o_strb = '0;
    o_err  = 1'b0;
    if (int'(i_size) > OFFW) begin
      o_err = 1'b1;
    end else if ((int'(i_offset) & ((1 << int'(i_size)) - 1)) != 0) begin
      o_err = 1'b1;
    end else begin
      for (int i = 0; i < NB; i++) begin
        o_strb[i] = (i >= int'(i_offset)) && (i < int'(i_offset) + (1 << int'(i_size)));
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pu_riscv_ahb3_slave_mem.sv
`default_nettype none
// ============================================================================
// Module   : pu_riscv_ahb3_slave_mem
// Brief    : AHB3-Lite slave memory with programmable wait states and ERROR response
// Revision : 1.0 - initial release
// ============================================================================
module pu_riscv_ahb3_slave_mem #(
  parameter int XLEN        = 32,
  parameter int PLEN        = 32,
  parameter int MEM_SIZE    = 4096,
  parameter int WAIT_STATES = 0
) (
  input  logic            HCLK,
  input  logic            HRESET,
  input  logic            HSEL,
  input  logic [PLEN-1:0] HADDR,
  input  logic [XLEN-1:0] HWDATA,
  output logic [XLEN-1:0] HRDATA,
  input  logic            HWRITE,
  input  logic [2:0]      HSIZE,
  input  logic [2:0]      HBURST,
  input  logic [3:0]      HPROT,
  input  logic [1:0]      HTRANS,
  input  logic            HMASTLOCK,
  input  logic            HREADY,
  output logic            HREADYOUT,
  output logic            HRESP
);

  import pu_riscv_ahb3_pkg::*;

  localparam int NB    = XLEN / 8;
  localparam int OFFW  = $clog2(NB);
  localparam int WORDS = MEM_SIZE / NB;
  localparam int AW    = $clog2(WORDS);

  localparam logic [PLEN-1:0] C_MEM_LIMIT = PLEN'(MEM_SIZE);
  localparam logic [3:0]      C_WAIT_INIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  ahb3_state_t     r_state;
  logic [3:0]      r_cnt;
  logic            r_hreadyout;
  logic            r_hresp;
  logic            r_write;
  logic [AW-1:0]   r_waddr;
  logic [NB-1:0]   r_strb;
  logic [XLEN-1:0] r_mem [WORDS];

  logic [NB-1:0]   w_strb;
  logic            w_align_err;
  logic            w_accept;
  logic            w_illegal;
  logic            w_commit;
  logic            w_unused;

  pu_riscv_ahb3_lanes #(
    .XLEN (XLEN)
  ) u_lanes (
    .i_offset (HADDR[OFFW-1:0]),
    .i_size   (HSIZE),
    .o_strb   (w_strb),
    .o_err    (w_align_err)
  );

  assign w_accept  = HSEL & HREADY & ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));
  assign w_illegal = w_align_err | (HADDR >= C_MEM_LIMIT);
  assign w_commit  = (r_state == ST_DATA) & r_write;
  assign w_unused  = ^{HBURST, HPROT, HMASTLOCK};

  // Only IDLE, DATA and ERR2 present HREADYOUT=1, so only they can see a new address phase
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_hreadyout <= 1'b1;
      r_hresp     <= HRESP_OKAY;
      r_write     <= 1'b0;
      r_waddr     <= '0;
      r_strb      <= '0;
    end else begin
      case (r_state)
        ST_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state     <= ST_DATA;
            r_hreadyout <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_ERR1: begin
          r_state     <= ST_ERR2;
          r_hreadyout <= 1'b1;
          r_hresp     <= HRESP_ERROR;
        end
        default: begin
          if (w_accept) begin
            r_write <= HWRITE;
            r_waddr <= HADDR[OFFW +: AW];
            r_strb  <= w_strb;
            if (w_illegal) begin
              r_state     <= ST_ERR1;
              r_hreadyout <= 1'b0;
              r_hresp     <= HRESP_ERROR;
            end else if (WAIT_STATES > 0) begin
              r_state     <= ST_WAIT;
              r_cnt       <= C_WAIT_INIT;
              r_hreadyout <= 1'b0;
              r_hresp     <= HRESP_OKAY;
            end else begin
              r_state     <= ST_DATA;
              r_hreadyout <= 1'b1;
              r_hresp     <= HRESP_OKAY;
            end
          end else begin
            r_state     <= ST_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= HRESP_OKAY;
          end
        end
      endcase
    end
  end

  // Async reset clears r_state first, so a write caught mid-transfer never commits
  always_ff @(posedge HCLK) begin
    if (w_commit) begin
      for (int i = 0; i < NB; i++) begin
        if (r_strb[i]) begin
          r_mem[r_waddr][i*8 +: 8] <= HWDATA[i*8 +: 8];
        end
      end
    end
  end

  assign HRDATA    = ((r_state == ST_DATA) && !r_write) ? r_mem[r_waddr] : '0;
  assign HREADYOUT = r_hreadyout;
  assign HRESP     = r_hresp;

endmodule
`default_nettype wire
